// File: rtl/memc3_pkg.sv
// Shared types and widths for the memc3 reset supervisor.
// The optional calibration watchdog is enabled by defining MEMC3_SUPV_CALIB_WATCHDOG_EN.
package memc3_pkg;

    localparam int CNT_W   = 20;
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        RST_ASSERT = 3'd0,
        WAIT_LOCK  = 3'd1,
        WAIT_CALIB = 3'd2,
        READY      = 3'd3,
        FAULT      = 3'd4
    } state_t;

endpackage

// File: rtl/memc3_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module memc3_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/memc3_reset_supervisor.sv
// Sequences memory PLL lock and MCB calibration with bounded retries and a sticky fault.
// Define MEMC3_SUPV_CALIB_WATCHDOG_EN to add a CALIB_TIMEOUT watchdog on WAIT_CALIB.
module memc3_reset_supervisor
    import memc3_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 65535,
    parameter int CALIB_TIMEOUT    = 1048575,
    parameter int MAX_RETRIES      = 3
) (
    input  logic               clk0,
    input  logic               rst0,
    input  logic               pll_lock,
    input  logic               calib_done,
    input  logic               clear_fault,
    output logic               sys_rst_n,
    output logic               mem_ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state
);

    if (RST_PULSE_CYCLES < 2 || LOCK_TIMEOUT < 1 || CALIB_TIMEOUT < 1 ||
        LOCK_TIMEOUT > (2 ** CNT_W) || CALIB_TIMEOUT > (2 ** CNT_W) ||
        MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_params
        $error("memc3_reset_supervisor: parameter out of range");
    end

    // Counter compares against N-1 so each phase lasts exactly N cycles including its entry cycle.
    localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
`ifdef MEMC3_SUPV_CALIB_WATCHDOG_EN
    localparam logic [CNT_W-1:0]   CALIB_LAST  = CNT_W'(CALIB_TIMEOUT - 1);
`endif

    state_t             cur;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [RETRY_W-1:0] retry_next;
    logic               lock_s;
    logic               calib_s;
    logic               fail;

    memc3_sync2 u_sync_lock (
        .clk (clk0),
        .rst (rst0),
        .d   (pll_lock),
        .q   (lock_s)
    );

    memc3_sync2 u_sync_calib (
        .clk (clk0),
        .rst (rst0),
        .d   (calib_done),
        .q   (calib_s)
    );

    assign state      = cur;
    assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    assign retry_next = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;

    // Lock loss outranks calib_done, and a lock arriving on the timeout cycle outranks the timeout.
    always_comb begin
        fail = 1'b0;
        case (cur)
            WAIT_LOCK:  fail = !lock_s && (cnt == LOCK_LAST);
`ifdef MEMC3_SUPV_CALIB_WATCHDOG_EN
            WAIT_CALIB: fail = !lock_s || (!calib_s && (cnt == CALIB_LAST));
`else
            WAIT_CALIB: fail = !lock_s;
`endif
            READY:      fail = !lock_s || !calib_s;
            default:    fail = 1'b0;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            cur       <= RST_ASSERT;
            cnt       <= '0;
            sys_rst_n <= 1'b0;
            mem_ready <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= '0;
        end else if (fail) begin
            retry_cnt <= retry_next;
            cnt       <= '0;
            sys_rst_n <= 1'b0;
            mem_ready <= 1'b0;
            if (retry_next >= RETRY_LIMIT) begin
                cur   <= FAULT;
                fault <= 1'b1;
            end else begin
                cur   <= RST_ASSERT;
            end
        end else begin
            case (cur)
                RST_ASSERT: begin
                    if (cnt == PULSE_LAST) begin
                        cur       <= WAIT_LOCK;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        cur <= WAIT_CALIB;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_CALIB: begin
                    if (calib_s) begin
                        cur       <= READY;
                        cnt       <= '0;
                        mem_ready <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                READY: begin
                    cnt <= '0;
                end
                FAULT: begin
                    cnt <= '0;
                    if (clear_fault) begin
                        cur       <= RST_ASSERT;
                        fault     <= 1'b0;
                        retry_cnt <= '0;
                    end
                end
                default: begin
                    cur       <= RST_ASSERT;
                    cnt       <= '0;
                    sys_rst_n <= 1'b0;
                    mem_ready <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule
